core_inst_seq: RTL and testbench

- Instruction sequencer that drives the 17-bit `inst` bus of the attention core, i.e. the initiator end of the core instruction interface.
- On `start` it issues one complete tile pass in order:
  - Q-memory fill and K-memory fill
  - kernel load into the MAC array
  - execute
  - drain of the output FIFO into psum memory
- Sits between the testbench/host controller and the core; it also provides the external data-source address for `mem_in`.

---
 rtl/core_inst_seq.sv | 103 ++++++++++
 tb/tb_core_inst_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq: issues one Q/K fill, kernel load, execute and drain pass on the core instruction bus
module core_inst_seq #(
  parameter int row_bits = 4,
  parameter int inst_bw = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [row_bits-1:0] num_rows,
  input  logic                ofifo_valid,
  output logic [inst_bw-1:0]  inst,
  output logic [row_bits-1:0] ext_addr,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, QWR, KWR, KLOAD, GAP, EXEC, DRAIN, DONE} state_t;
  localparam logic [row_bits:0] one = {{row_bits{1'b0}}, 1'b1};
  localparam logic [row_bits:0] full = {1'b1, {row_bits{1'b0}}};
  localparam logic [row_bits-1:0] pone = {{(row_bits-1){1'b0}}, 1'b1};
  state_t state;
  logic [row_bits:0] n, rc;
  logic [row_bits-1:0] pc;
  logic last_n, last_x, last_p, first;
  // rc carries an extra bit so the N+1-cycle phases can reach N even when N is 16
  assign last_n = rc + one == n;
  assign last_x = rc == n;
  assign last_p = {1'b0, pc} + one == n;
  assign first = rc < n;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      n <= '0;
      rc <= '0;
      pc <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= QWR;
          rc <= '0;
          n <= num_rows == '0 ? full : {1'b0, num_rows};
        end
        QWR: begin
          rc <= last_n ? '0 : rc + one;
          if (last_n) state <= KWR;
        end
        KWR: begin
          rc <= last_n ? '0 : rc + one;
          if (last_n) state <= KLOAD;
        end
        KLOAD: begin
          rc <= last_x ? '0 : rc + one;
          if (last_x) state <= GAP;
        end
        GAP: begin
          rc <= '0;
          state <= EXEC;
        end
        EXEC: begin
          rc <= last_x ? '0 : rc + one;
          pc <= '0;
          if (last_x) state <= DRAIN;
        end
        DRAIN: if (ofifo_valid) begin
          pc <= pc + pone;
          if (last_p) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  always_comb begin
    inst = '0;
    ext_addr = '0;
    case (state)
      QWR: begin
        inst[15:12] = rc[row_bits-1:0];
        inst[4] = 1'b1;
        ext_addr = rc[row_bits-1:0];
      end
      KWR: begin
        inst[15:12] = rc[row_bits-1:0];
        inst[2] = 1'b1;
        ext_addr = rc[row_bits-1:0];
      end
      KLOAD: begin
        inst[15:12] = first ? rc[row_bits-1:0] : '0;
        inst[6] = 1'b1;
        inst[3] = first;
      end
      EXEC: begin
        inst[15:12] = first ? rc[row_bits-1:0] : '0;
        inst[7] = 1'b1;
        inst[5] = first;
      end
      DRAIN: begin
        inst[16] = ofifo_valid;
        inst[11:8] = pc;
        inst[0] = ofifo_valid;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: randomized passes compared cycle by cycle against a per-phase reference model
module tb_core_inst_seq;
  logic clk = 0, reset = 0, start = 0, ofifo_valid = 0;
  logic [3:0] num_rows = 0;
  logic [16:0] inst;
  logic [3:0] ext_addr;
  logic busy, done;
  int checks = 0, failures = 0;
  int vq[$];

  always #5 clk = ~clk;

  core_inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .ofifo_valid(ofifo_valid), .inst(inst), .ext_addr(ext_addr),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(int i, int e, bit b, bit d);
    return 32'((i << 6) | (e << 2) | (int'(b) << 1) | int'(d));
  endfunction

  task automatic cyc(input string tag, input logic [31:0] exp);
    check(tag, {9'b0, inst, ext_addr, busy, done}, exp);
    check("onehot", 32'(($countones({inst[5:2], inst[0]}) <= 1) && !inst[1]), 32'd1);
  endtask

  task automatic run_pass(input logic [3:0] nr, input bit rnd, input bit hold, input int abort);
    int n, pops, t;
    bit v;
    n = (nr == 0) ? 16 : int'(nr);
    pops = 0;
    t = 0;
    @(negedge clk); num_rows = nr; start = 1; #1 cyc("idle", pk(0, 0, 0, 0));
    for (int r = 0; r < n; r++) begin
      @(negedge clk); start = hold; num_rows = 4'($urandom); #1 cyc("qwr", pk((r << 12) | 'h10, r, 1, 0));
    end
    for (int r = 0; r < n; r++) begin
      @(negedge clk); #1 cyc("kwr", pk((r << 12) | 'h04, r, 1, 0));
    end
    for (int r = 0; r <= n; r++) begin
      @(negedge clk); #1 cyc("kload", pk(r < n ? (r << 12) | 'h48 : 'h40, 0, 1, 0));
    end
    @(negedge clk); #1 cyc("gap", pk(0, 0, 1, 0));
    for (int r = 0; r <= n; r++) begin
      @(negedge clk); #1 cyc("exec", pk(r < n ? (r << 12) | 'hA0 : 'h80, 0, 1, 0));
      if (r == abort) begin
        reset = 0;
        @(negedge clk); reset = 1; #1 cyc("abort", pk(0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); ofifo_valid = 1; #1 cyc("abort_idle", pk(0, 0, 0, 0));
        end
        ofifo_valid = 0;
        return;
      end
    end
    while (pops < n && t < 400) begin
      @(negedge clk);
      v = vq.size() > 0 ? vq.pop_front() != 0 : (rnd ? $urandom_range(0, 1) != 0 : 1'b1);
      ofifo_valid = v;
      #1 cyc("drain", pk((int'(v) << 16) | (pops << 8) | int'(v), 0, 1, 0));
      if (v) pops++;
      t++;
    end
    check("drain_pops", pops, n);
    @(negedge clk); ofifo_valid = $urandom_range(0, 1) != 0; #1 cyc("done", pk(0, 0, 1, 1));
    @(negedge clk); ofifo_valid = 0; #1 cyc("post", pk(0, 0, 0, 0));
    if (hold) begin
      @(negedge clk); start = 0; #1 cyc("rehold", pk('h10, 0, 1, 0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 0; start = 0; ofifo_valid = 0;
    @(negedge clk); reset = 1; #1 cyc("reset", pk(0, 0, 0, 0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    #1 cyc("reset_state", pk(0, 0, 0, 0));
    run_pass(4'd4, 0, 0, -1);
    run_pass(4'd0, 0, 0, -1);
    vq = '{1, 0, 0, 1};
    run_pass(4'd2, 0, 0, -1);
    run_pass(4'd3, 0, 1, -1);
    do_reset();
    run_pass(4'd8, 0, 0, 2);
    run_pass(4'd8, 0, 0, -1);
    for (int i = 0; i < 8; i++) run_pass(4'($urandom_range(0, 15)), 1, 0, -1);
    run_pass(4'd1, 1, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
